// File: rtl/apb_timer_pkg.sv
//------------------------------------------------------------------------------
// apb_timer_pkg : register map, CTRL layout and shared types for apb_timer
// Revision      : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package apb_timer_pkg;

  localparam logic [7:0] ADDR_CTRL   = 8'h00;
  localparam logic [7:0] ADDR_STATUS = 8'h01;
  localparam logic [7:0] ADDR_TDR    = 8'h02;
  localparam logic [7:0] ADDR_CNT    = 8'h03;

  localparam int CTRL_LOAD_BIT   = 7;
  localparam int CTRL_DIR_BIT    = 5;
  localparam int CTRL_EN_BIT     = 4;
  localparam int CTRL_UDF_IE_BIT = 3;
  localparam int CTRL_OVF_IE_BIT = 2;
  localparam int CTRL_CKS_LSB    = 0;

  localparam int STAT_UDF_BIT = 1;
  localparam int STAT_OVF_BIT = 0;

  localparam logic [7:0] CNT_MAX = 8'hFF;

  typedef struct packed {
    logic       load;
    logic       rsvd;
    logic       dir;
    logic       en;
    logic       udf_ie;
    logic       ovf_ie;
    logic [1:0] cks;
  } ctrl_t;

endpackage

`default_nettype wire

// File: rtl/timer_counter.sv
//------------------------------------------------------------------------------
// timer_counter : prescaler, 8-bit up/down counter and OVF/UDF set pulses
// Revision      : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module timer_counter
  import apb_timer_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       en_i,
  input  logic       dir_i,
  input  logic [1:0] cks_i,
  input  logic       load_i,
  input  logic [7:0] load_val_i,
  output logic [7:0] cnt_o,
  output logic       ovf_set_o,
  output logic       udf_set_o
);

  logic [1:0] presc_q, presc_d;
  logic [7:0] cnt_q, cnt_d;
  logic       tick;

  always_comb begin
    tick      = en_i && (presc_q == cks_i);
    presc_d   = presc_q;
    cnt_d     = cnt_q;
    ovf_set_o = 1'b0;
    udf_set_o = 1'b0;
    // LOAD wins over a coincident tick and restarts the prescale period
    if (load_i) begin
      cnt_d   = load_val_i;
      presc_d = 2'd0;
    end else if (!en_i) begin
      presc_d = 2'd0;
    end else if (tick) begin
      presc_d = 2'd0;
      if (dir_i) begin
        cnt_d     = cnt_q - 8'd1;
        udf_set_o = (cnt_q == 8'd0);
      end else begin
        cnt_d     = cnt_q + 8'd1;
        ovf_set_o = (cnt_q == CNT_MAX);
      end
    end else begin
      presc_d = presc_q + 2'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      presc_q <= 2'd0;
      cnt_q   <= 8'd0;
    end else begin
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

`default_nettype wire

// File: rtl/apb_timer.sv
//------------------------------------------------------------------------------
// apb_timer : 8-bit programmable timer with APB register file and interrupt
// Revision  : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module apb_timer
  import apb_timer_pkg::*;
(
  input  logic       pclk,
  input  logic       preset_n,
  input  logic       psel,
  input  logic       penable,
  input  logic       pwrite,
  input  logic [7:0] paddr,
  input  logic [7:0] pwdata,
  output logic [7:0] prdata,
  output logic       pready,
  output logic       pslverr,
  output logic       interrupt
);

  ctrl_t      ctrl_q, ctrl_d;
  logic [7:0] tdr_q, tdr_d;
  logic       ovf_q, ovf_d, udf_q, udf_d;
  logic       pready_q, pslverr_q;
  logic [7:0] prdata_q, prdata_d;

  logic       access, addr_err, wr;
  logic       ctrl_wr, status_wr, tdr_wr, load;
  logic [7:0] cnt, rdata;
  logic       ovf_set, udf_set;

  always_comb begin
    // !pready_q keeps a held psel&penable from producing a second access
    access    = psel && penable && !pready_q;
    addr_err  = (paddr > ADDR_CNT) || (pwrite && (paddr == ADDR_CNT));
    wr        = access && pwrite && !addr_err;
    ctrl_wr   = wr && (paddr == ADDR_CTRL);
    status_wr = wr && (paddr == ADDR_STATUS);
    tdr_wr    = wr && (paddr == ADDR_TDR);
    load      = ctrl_wr && pwdata[CTRL_LOAD_BIT];

    ctrl_d = ctrl_q;
    if (ctrl_wr) begin
      ctrl_d.load   = 1'b0;
      ctrl_d.rsvd   = 1'b0;
      ctrl_d.dir    = pwdata[CTRL_DIR_BIT];
      ctrl_d.en     = pwdata[CTRL_EN_BIT];
      ctrl_d.udf_ie = pwdata[CTRL_UDF_IE_BIT];
      ctrl_d.ovf_ie = pwdata[CTRL_OVF_IE_BIT];
      ctrl_d.cks    = pwdata[CTRL_CKS_LSB +: 2];
    end
    tdr_d = tdr_wr ? pwdata : tdr_q;

    // a set in the same cycle beats the W1C clear
    ovf_d = ovf_set || (ovf_q && !(status_wr && pwdata[STAT_OVF_BIT]));
    udf_d = udf_set || (udf_q && !(status_wr && pwdata[STAT_UDF_BIT]));

    case (paddr)
      ADDR_CTRL:   rdata = ctrl_q;
      ADDR_STATUS: rdata = {6'd0, udf_q, ovf_q};
      ADDR_TDR:    rdata = tdr_q;
      ADDR_CNT:    rdata = cnt;
      default:     rdata = 8'h00;
    endcase

    prdata_d = prdata_q;
    if (access && !pwrite) prdata_d = addr_err ? 8'h00 : rdata;
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      ctrl_q    <= '0;
      tdr_q     <= 8'h00;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= 8'h00;
    end else begin
      ctrl_q    <= ctrl_d;
      tdr_q     <= tdr_d;
      ovf_q     <= ovf_d;
      udf_q     <= udf_d;
      pready_q  <= access;
      pslverr_q <= access && addr_err;
      prdata_q  <= prdata_d;
    end
  end

  timer_counter u_counter (
    .clk_i      (pclk),
    .rst_ni     (preset_n),
    .en_i       (ctrl_q.en),
    .dir_i      (ctrl_q.dir),
    .cks_i      (ctrl_q.cks),
    .load_i     (load),
    .load_val_i (tdr_q),
    .cnt_o      (cnt),
    .ovf_set_o  (ovf_set),
    .udf_set_o  (udf_set)
  );

  assign prdata    = prdata_q;
  assign pready    = pready_q;
  assign pslverr   = pslverr_q;
  assign interrupt = (udf_q && ctrl_q.udf_ie) || (ovf_q && ctrl_q.ovf_ie);

endmodule

`default_nettype wire

// File: tb/tb_apb_timer.sv
//------------------------------------------------------------------------------
// tb_apb_timer : scoreboard bench for apb_timer (directed APB vectors)
// Revision     : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_apb_timer;

  logic       pclk = 1'b0;
  logic       preset_n = 1'b0;
  logic       psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [7:0] paddr = 8'h00, pwdata = 8'h00;
  logic [7:0] prdata;
  logic       pready, pslverr, interrupt;

  typedef struct {
    logic [7:0] data;
    logic       err;
    logic       chk_data;
    string      name;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  logic prev_rdy = 1'b0;

  apb_timer dut (
    .pclk      (pclk),
    .preset_n  (preset_n),
    .psel      (psel),
    .penable   (penable),
    .pwrite    (pwrite),
    .paddr     (paddr),
    .pwdata    (pwdata),
    .prdata    (prdata),
    .pready    (pready),
    .pslverr   (pslverr),
    .interrupt (interrupt)
  );

  always #5 pclk = ~pclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%02h required 0x%02h", name, act, exp);
    end
  endtask

  // Monitor: pops one expectation per pready pulse, and checks pready drops
  always @(negedge pclk) begin
    if (!preset_n) begin
      prev_rdy <= 1'b0;
    end else begin
      if (prev_rdy) check("pready_single_cycle", {7'd0, pready}, 8'h00);
      if (pready) begin
        if (q.size() == 0) begin
          check("unexpected_pready", 8'h01, 8'h00);
        end else begin
          exp_t e;
          e = q.pop_front();
          check({e.name, "_pslverr"}, {7'd0, pslverr}, {7'd0, e.err});
          if (e.chk_data) check({e.name, "_prdata"}, prdata, e.data);
        end
      end
      prev_rdy <= pready;
    end
  end

  task automatic apb(input logic wr, input logic [7:0] addr, input logic [7:0] wdata,
                     input logic [7:0] exp_data, input logic exp_err, input string name);
    exp_t e;
    e.data = exp_data; e.err = exp_err; e.chk_data = !wr; e.name = name;
    q.push_back(e);
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge pclk);
    #1 preset_n = 1'b1;
    #1;
    check("rst_pready", {7'd0, pready}, 8'h00);
    check("rst_pslverr", {7'd0, pslverr}, 8'h00);
    check("rst_prdata", prdata, 8'h00);
    check("rst_interrupt", {7'd0, interrupt}, 8'h00);
    for (int a = 0; a < 4; a++) apb(1'b0, 8'(a), 8'h00, 8'h00, 1'b0, "rst_read");

    apb(1'b1, 8'h02, 8'h64, 8'h00, 1'b0, "wr_tdr");
    apb(1'b1, 8'h00, 8'h80, 8'h00, 1'b0, "wr_load");
    apb(1'b0, 8'h03, 8'h00, 8'h64, 1'b0, "rd_cnt_loaded");
    apb(1'b0, 8'h00, 8'h00, 8'h00, 1'b0, "rd_ctrl_selfclr");

    // down count from 0x64 with CKS=3: underflow at (100+1)*(3+1) = 404 edges
    apb(1'b1, 8'h00, 8'h3B, 8'h00, 1'b0, "wr_ctrl_down");
    repeat (403) @(posedge pclk);
    #1 check("irq_before_udf", {7'd0, interrupt}, 8'h00);
    @(posedge pclk);
    #1 check("irq_at_udf", {7'd0, interrupt}, 8'h01);
    apb(1'b0, 8'h01, 8'h00, 8'h02, 1'b0, "rd_status_udf");
    apb(1'b1, 8'h01, 8'h02, 8'h00, 1'b0, "w1c_udf");
    check("irq_after_w1c", {7'd0, interrupt}, 8'h00);
    apb(1'b0, 8'h01, 8'h00, 8'h00, 1'b0, "rd_status_clr");
    apb(1'b1, 8'h00, 8'h00, 8'h00, 1'b0, "wr_ctrl_off");

    // up count from 0xFE, CKS=0: FF after edge 1, wraps to 00 (OVF) at edge 2
    apb(1'b1, 8'h02, 8'hFE, 8'h00, 1'b0, "wr_tdr_fe");
    apb(1'b1, 8'h00, 8'h80, 8'h00, 1'b0, "wr_load_fe");
    apb(1'b1, 8'h00, 8'h14, 8'h00, 1'b0, "wr_ctrl_up");
    @(posedge pclk);
    #1 check("irq_before_ovf", {7'd0, interrupt}, 8'h00);
    @(posedge pclk);
    #1 check("irq_at_ovf", {7'd0, interrupt}, 8'h01);
    // read captured two edges after the wrap, so the counter has moved on to 0x02
    apb(1'b0, 8'h03, 8'h00, 8'h02, 1'b0, "rd_cnt_after_ovf");
    apb(1'b0, 8'h01, 8'h00, 8'h01, 1'b0, "rd_status_ovf");

    apb(1'b1, 8'h03, 8'h55, 8'h00, 1'b1, "wr_cnt_err");
    apb(1'b1, 8'h10, 8'hAA, 8'h00, 1'b1, "wr_oob_err");
    apb(1'b0, 8'h10, 8'h00, 8'h00, 1'b1, "rd_oob_err");
    apb(1'b0, 8'h02, 8'h00, 8'hFE, 1'b0, "rd_tdr_unchanged");
    apb(1'b0, 8'h00, 8'h00, 8'h14, 1'b0, "rd_ctrl_unchanged");

    // asynchronous reset while counting with the OVF interrupt pending
    @(posedge pclk);
    #3 check("irq_before_reset", {7'd0, interrupt}, 8'h01);
    preset_n = 1'b0;
    #1;
    check("async_rst_irq", {7'd0, interrupt}, 8'h00);
    check("async_rst_prdata", prdata, 8'h00);
    repeat (2) @(posedge pclk);
    #1 preset_n = 1'b1;
    apb(1'b0, 8'h03, 8'h00, 8'h00, 1'b0, "rd_cnt_after_rst");
    apb(1'b0, 8'h00, 8'h00, 8'h00, 1'b0, "rd_ctrl_after_rst");

    repeat (5) @(posedge pclk);
    #1 check("scoreboard_drained", 8'(q.size()), 8'h00);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
